// File: rtl/sample_decimator.sv
// ---------------------------------------------------------------------------
// sample_decimator
//
// Rate reducer between the FIR stage and capture memory. Accepts signed
// samples qualified by in_valid and emits one result per block of
// N = ratio + 1 accepted samples:
//   mode 0/3 : pick   - the last (Nth) sample of the block
//   mode 1   : peak   - block maximum on data_out, block minimum on data_min
//   mode 2   : average when DECIM_AVERAGE_EN is defined, otherwise pick
// ratio, mode (and avg_shift) are sampled only at block start: the first
// edge after reset release, a restart, or the edge that completes a block.
//
// Optional feature macro: DECIM_AVERAGE_EN
//   Adds port avg_shift[4:0] and the average mode. The block sum is kept in a
//   DATA_WIDTH+RATIO_WIDTH accumulator, arithmetically shifted right by
//   avg_shift and saturated to the signed DATA_WIDTH range.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   restart             synchronous clear of block state (keeps overrun)
//   in_valid, data_in   input sample stream
//   ratio, mode         block length minus one, reduction mode
//   avg_shift           average divisor exponent (DECIM_AVERAGE_EN only)
//   out_valid/out_ready output handshake
//   data_out, data_min  result (max/min in peak mode, equal otherwise)
//   overrun             sticky: an unconsumed result was overwritten
//   overrun_clr         synchronous clear of overrun (a new overrun wins)
// ---------------------------------------------------------------------------
module sample_decimator #(
    parameter int DATA_WIDTH  = 12,
    parameter int RATIO_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic [RATIO_WIDTH-1:0] ratio,
    input  logic [1:0]             mode,
`ifdef DECIM_AVERAGE_EN
    input  logic [4:0]             avg_shift,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [DATA_WIDTH-1:0]  data_min,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam logic [1:0] MODE_PEAK = 2'd1;

    logic                          cfg_pending;  // first edge after reset still has to load config
    logic [RATIO_WIDTH-1:0]        ratio_q;
    logic [RATIO_WIDTH-1:0]        ratio_eff;
    logic [RATIO_WIDTH-1:0]        cnt;
    logic [1:0]                    mode_q;
    logic [1:0]                    mode_eff;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic signed [DATA_WIDTH-1:0]  max_q;
    logic signed [DATA_WIDTH-1:0]  min_q;
    logic signed [DATA_WIDTH-1:0]  blk_max;
    logic signed [DATA_WIDTH-1:0]  blk_min;
    logic signed [DATA_WIDTH-1:0]  pick_val;
    logic                          accept;
    logic                          first;
    logic                          last;

`ifdef DECIM_AVERAGE_EN
    localparam logic [1:0] MODE_AVG = 2'd2;
    localparam int         ACC_W    = DATA_WIDTH + RATIO_WIDTH;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(RATIO_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(RATIO_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [4:0]              shift_q;
    logic [4:0]              shift_eff;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [DATA_WIDTH-1:0] avg_val;
`endif

    // NOTE: every signal written here gets a value on every path first, so no
    // latch can be inferred.
    always_comb begin
        // Until the first post-reset edge has loaded the registers, the live
        // inputs are the configuration of the block being started.
        ratio_eff = cfg_pending ? ratio : ratio_q;
        mode_eff  = cfg_pending ? mode  : mode_q;
        sample    = $signed(data_in);
        accept    = in_valid && !restart;   // restart discards a coincident sample
        first     = (cnt == '0);
        last      = accept && (cnt == ratio_eff);

        if (first) begin
            blk_max = sample;
            blk_min = sample;
        end else begin
            blk_max = (sample > max_q) ? sample : max_q;
            blk_min = (sample < min_q) ? sample : min_q;
        end

        pick_val = sample;
`ifdef DECIM_AVERAGE_EN
        shift_eff = cfg_pending ? avg_shift : shift_q;
        acc_sum   = (first ? '0 : acc_q) + {{RATIO_WIDTH{sample[DATA_WIDTH-1]}}, sample};
        acc_shr   = acc_sum >>> shift_eff;
        if (acc_shr > SAT_MAX) begin
            avg_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_shr < SAT_MIN) begin
            avg_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            avg_val = acc_shr[DATA_WIDTH-1:0];
        end
        if (mode_eff == MODE_AVG) begin
            pick_val = avg_val;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pending <= 1'b1;
            ratio_q     <= '0;
            mode_q      <= '0;
            cnt         <= '0;
            max_q       <= '0;
            min_q       <= '0;
            out_valid   <= 1'b0;
            data_out    <= '0;
            data_min    <= '0;
            overrun     <= 1'b0;
`ifdef DECIM_AVERAGE_EN
            shift_q     <= '0;
            acc_q       <= '0;
`endif
        end else begin
            if (restart) begin
                cfg_pending <= 1'b0;
                ratio_q     <= ratio;
                mode_q      <= mode;
                cnt         <= '0;
                max_q       <= '0;
                min_q       <= '0;
                out_valid   <= 1'b0;
`ifdef DECIM_AVERAGE_EN
                shift_q     <= avg_shift;
                acc_q       <= '0;
`endif
            end else begin
                if (cfg_pending || last) begin
                    // Block boundary: config for the next block is taken now.
                    cfg_pending <= 1'b0;
                    ratio_q     <= ratio;
                    mode_q      <= mode;
`ifdef DECIM_AVERAGE_EN
                    shift_q     <= avg_shift;
`endif
                end

                if (accept) begin
                    if (last) begin
                        cnt <= '0;
                    end else begin
                        cnt   <= cnt + RATIO_WIDTH'(1);
                        max_q <= blk_max;
                        min_q <= blk_min;
`ifdef DECIM_AVERAGE_EN
                        acc_q <= acc_sum;
`endif
                    end
                end

                if (last) begin
                    out_valid <= 1'b1;
                    data_out  <= (mode_eff == MODE_PEAK) ? blk_max : pick_val;
                    data_min  <= (mode_eff == MODE_PEAK) ? blk_min : pick_val;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end

            // A new overrun beats a coincident clear.
            if (last && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
